// File: rtl/phase_a_pkg.sv
// Shared definitions for the modular-multiplication phase A sequencers.
//   SIZE / RADIX / NDIG : default operand width, digit width, digits per operand
//   clog2               : constant-evaluable ceil(log2(value))
//   sched_state_t       : inner_loop_sched FSM state encoding
package phase_a_pkg;

    localparam int SIZE  = 3072;
    localparam int RADIX = 54;
    localparam int NDIG  = (SIZE + RADIX - 1) / RADIX;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/inner_loop_sched_digit_mux.sv
// digit_mux: selects digit idx of the captured operand, least significant first.
// The operand is zero-extended to NDIG*radix bits, so the top digit carries
// only the Size - (NDIG-1)*radix real bits and zeros above them.
// Ports:
//   b_word in  Size  : captured multiplier operand
//   idx    in  IW    : digit index (values >= NDIG select zero)
//   digit  out radix : selected digit
module digit_mux
    import phase_a_pkg::*;
#(
    parameter int Size  = SIZE,
    parameter int radix = RADIX,
    parameter int NDIG  = (Size + radix - 1) / radix,
    parameter int IW    = clog2(NDIG)
) (
    input  logic [Size-1:0]  b_word,
    input  logic [IW-1:0]    idx,
    output logic [radix-1:0] digit
);

    localparam int EW = NDIG * radix;

    logic [EW-1:0] b_ext;

    assign b_ext = EW'(b_word);

    // Constant-offset selects keep every slice in range for any idx value.
    always_comb begin
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) digit = b_ext[i*radix +: radix];
        end
    end

endmodule

// File: rtl/inner_loop_sched.sv
// inner_loop_sched: walks a Size-bit multiplier through the inner_loop_new row
// engine one radix-bit digit at a time (clear, issue, wait, hand row downstream),
// then pulses done.
// Optional watchdog: define INNER_LOOP_SCHED_TIMEOUT_EN to abort a pass whose
// il_done has not arrived within TIMEOUT cycles of WAIT and raise sticky err.
// Ports:
//   clk, rst (async, active-high; shared with the row engine)
//   start, b        : job request and operand (sampled in IDLE only)
//   abort           : cancel current job
//   busy            : FSM not in IDLE
//   il_clr, il_en   : row engine clear / pass-start pulses
//   il_bi           : current digit
//   il_done         : pass complete from the row engine
//   row_valid/row_ready, row_idx, row_last : downstream row token
//   done            : job complete pulse
//   err             : watchdog fired (constant 0 without the macro)
module inner_loop_sched
    import phase_a_pkg::*;
#(
    parameter int Size    = SIZE,
    parameter int radix   = RADIX,
    parameter int NDIG    = (Size + radix - 1) / radix,
    parameter int IW      = clog2(NDIG),
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Size-1:0]  b,
    input  logic             abort,
    output logic             busy,
    output logic             il_clr,
    output logic             il_en,
    output logic [radix-1:0] il_bi,
    input  logic             il_done,
    output logic             row_valid,
    output logic [IW-1:0]    row_idx,
    output logic             row_last,
    input  logic             row_ready,
    output logic             done,
    output logic             err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [Size-1:0] b_q, b_d;
    logic            abort_clr_q, abort_clr_d;

`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
    localparam int           CW      = clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        b_d         = b_q;
        abort_clr_d = 1'b0;
`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    b_d     = b;
                    idx_d   = '0;
                    state_d = ST_CLR;
`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_CLR:   state_d = ST_ISSUE;
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (il_done) state_d = ST_OUT;
`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    // Stuck engine: treat exactly like an abort.
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                    abort_clr_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            ST_OUT: begin
                if (row_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_CLR;
                    end
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort wins over everything; the engine is cleared on the way out so a
        // half-finished row never leaks into the next job.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            abort_clr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            b_q         <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            b_q         <= b_d;
            abort_clr_q <= abort_clr_d;
        end
    end

`ifdef INNER_LOOP_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    // No watchdog: err is permanently low whatever TIMEOUT is set to.
    assign err = 1'b0 & (TIMEOUT != 0);
`endif

    digit_mux #(
        .Size  (Size),
        .radix (radix),
        .NDIG  (NDIG),
        .IW    (IW)
    ) u_digit_mux (
        .b_word (b_q),
        .idx    (idx_q),
        .digit  (il_bi)
    );

    assign busy      = (state_q != ST_IDLE);
    assign il_clr    = (state_q == ST_CLR) | abort_clr_q;
    assign il_en     = (state_q == ST_ISSUE);
    assign row_valid = (state_q == ST_OUT);
    assign row_idx   = idx_q;
    assign row_last  = row_valid & (idx_q == LAST_IDX);
    assign done      = (state_q == ST_FIN);

endmodule
